synth_regfile: RTL and testbench
================================

SYNTH_REGFILE -- requirements
Module: synth_regfile

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 4, number of entries (2..64; need not be a power of two).
REQ-003 Parameter NEGEDGE, default 1, active edge select: 1 = falling edge of clk, 0 = rising edge.
REQ-004 Parameter AW, default 2, address width = clog2(DEPTH).
REQ-005 clk  input  1  sole clock; all state updates on the edge selected by NEGEDGE.
REQ-006 rst_n  input  1  reset, synchronous, active-low, sampled on the active edge.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  AW  write address.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 inv  input  1  invalidate enable.
REQ-011 iaddr  input  AW  invalidate address.
REQ-012 raddr0 / raddr1  input  AW  read addresses, ports 0 and 1.
REQ-013 rdata0 / rdata1  output  WIDTH  asynchronous read data.
REQ-014 rvalid0 / rvalid1  output  1  valid bit of the addressed entry.
REQ-015 count  output  clog2(DEPTH+1)  number of valid entries.

Function
REQ-016 Storage: DEPTH entries of WIDTH bits, each with one valid bit.
REQ-017 Write: on the active edge with we=1 and waddr<DEPTH, entry[waddr] takes wdata and its valid bit is set.
REQ-018 Invalidate: on the active edge with inv=1 and iaddr<DEPTH, the valid bit of entry[iaddr] is cleared; data is retained.
REQ-019 Writes and invalidates occur on the active edge only; the inactive edge changes no state.
REQ-020 Read is combinational: rdata/rvalid follow raddr and storage with zero cycles of latency; write data is visible on rdata in the same timestep as the active edge that stores it.
REQ-021 Read of an invalid entry returns the stored data with rvalid=0.
REQ-022 Address >= DEPTH: writes and invalidates are ignored; reads return rdata=0 and rvalid=0.
REQ-023 Both read ports are independent and may address the same entry.
REQ-024 Simultaneous we and inv to the same valid address: write wins; the entry ends valid with wdata and count is unchanged.
REQ-025 Simultaneous we and inv to different addresses: both take effect in the same edge.
REQ-026 count updates on the same edge: +1 if an invalid entry is written, -1 if a valid entry is invalidated, net effect when both occur; writing a valid entry or invalidating an invalid one leaves count unchanged.
REQ-027 count never exceeds DEPTH and never wraps below 0.

Reset
REQ-028 rst_n=0 at an active edge clears all valid bits, clears all data to 0, and sets count=0; this takes priority over we and inv at that edge.
REQ-029 After reset, all rdata=0, rvalid=0, and count=0, independent of raddr.
REQ-030 Reset asserted mid-operation discards any write or invalidate presented at that edge; operation resumes at the first active edge with rst_n=1.
REQ-031 Before the first reset edge, outputs are X in simulation; no initial values are required.

Verification
REQ-032 With NEGEDGE=1, reset, then we=1, waddr=1, wdata=8'hA5, and clk rising: rdata0(raddr0=1)=0 and rvalid0=0; on clk falling: rdata0=8'hA5, rvalid0=1, count=1.
REQ-033 With NEGEDGE=0, apply the same stimulus: the write lands on the rising edge, and the falling edge changes nothing.
REQ-034 Write 0x11, 0x22, 0x33, 0x44 to addresses 0..3, then rewrite address 2 with 0x55: count=4 throughout the rewrite; rdata1(raddr1=2)=0x55.
REQ-035 With entry 3 valid, set we=1, waddr=3, wdata=0x77, inv=1, iaddr=3: entry 3 is valid with 0x77 and count is unchanged; then inv alone on iaddr=3: rvalid=0, rdata=0x77, count decrements by 1.
REQ-036 With DEPTH=3, AW=2: a write to address 3 is ignored (count unchanged); raddr0=3 returns rdata0=0 and rvalid0=0.
REQ-037 Fill all entries, then pull rst_n low for one edge while we=1: count=0, all rvalid=0, rdata=0, and the write is dropped.

Source files
------------

// File: rtl/synth_regfile.sv
// Small register file with per-entry valid bits, two combinational read ports,
// one write port, one invalidate port and a running count of valid entries.
module synth_regfile #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NEGEDGE = 1,
    parameter int unsigned AW      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         inv,
    input  logic [AW-1:0]                iaddr,
    input  logic [AW-1:0]                raddr0,
    input  logic [AW-1:0]                raddr1,
    output logic [WIDTH-1:0]             rdata0,
    output logic [WIDTH-1:0]             rdata1,
    output logic                         rvalid0,
    output logic                         rvalid1,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_data_nxt [DEPTH];
    logic [DEPTH-1:0] w_valid_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_we_ok;
    logic             w_inv_ok;
    logic             w_inc;
    logic             w_dec;
    logic             w_r0_ok;
    logic             w_r1_ok;

    // Out-of-range addresses are legal inputs when DEPTH is not a power of two.
    assign w_we_ok  = we  && (32'(waddr)  < DEPTH);
    assign w_inv_ok = inv && (32'(iaddr)  < DEPTH);
    assign w_r0_ok  = (32'(raddr0) < DEPTH);
    assign w_r1_ok  = (32'(raddr1) < DEPTH);

    // Count moves only on real valid-bit transitions; a write to the entry being
    // invalidated wins, so that invalidate never decrements.
    assign w_inc = w_we_ok && !r_valid[waddr];
    assign w_dec = w_inv_ok && r_valid[iaddr] && !(w_we_ok && (waddr == iaddr));

    always_comb begin
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count + CW'(w_inc) - CW'(w_dec);
        if (w_inv_ok) begin
            w_valid_nxt[iaddr] = 1'b0;
        end
        if (w_we_ok) begin
            w_valid_nxt[waddr] = 1'b1;
            w_data_nxt[waddr]  = wdata;
        end
    end

    // State register on the edge chosen by NEGEDGE; reset is sampled on that edge.
    generate
        if (NEGEDGE != 0) begin : g_neg
            always_ff @(negedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_data[i] <= '0;
                    end
                    r_valid <= '0;
                    r_count <= '0;
                end else begin
                    r_data  <= w_data_nxt;
                    r_valid <= w_valid_nxt;
                    r_count <= w_count_nxt;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_data[i] <= '0;
                    end
                    r_valid <= '0;
                    r_count <= '0;
                end else begin
                    r_data  <= w_data_nxt;
                    r_valid <= w_valid_nxt;
                    r_count <= w_count_nxt;
                end
            end
        end
    endgenerate

    assign rdata0  = w_r0_ok ? r_data[raddr0]  : '0;
    assign rvalid0 = w_r0_ok ? r_valid[raddr0] : 1'b0;
    assign rdata1  = w_r1_ok ? r_data[raddr1]  : '0;
    assign rvalid1 = w_r1_ok ? r_valid[raddr1] : 1'b0;
    assign count   = r_count;

endmodule

// File: tb/tb_synth_regfile.sv
// Directed bench: falling-edge, rising-edge and DEPTH=3 instances share one stimulus.
module tb_synth_regfile;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       inv;
    logic [1:0] iaddr;
    logic [1:0] raddr0;
    logic [1:0] raddr1;

    logic [7:0] n_rdata0, n_rdata1, p_rdata0, p_rdata1, d_rdata0, d_rdata1;
    logic       n_rvalid0, n_rvalid1, p_rvalid0, p_rvalid1, d_rvalid0, d_rvalid1;
    logic [2:0] n_count, p_count;
    logic [1:0] d_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    synth_regfile #(.WIDTH(8), .DEPTH(4), .NEGEDGE(1), .AW(2)) u_neg (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .inv(inv), .iaddr(iaddr), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(n_rdata0), .rdata1(n_rdata1), .rvalid0(n_rvalid0),
        .rvalid1(n_rvalid1), .count(n_count)
    );

    synth_regfile #(.WIDTH(8), .DEPTH(4), .NEGEDGE(0), .AW(2)) u_pos (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .inv(inv), .iaddr(iaddr), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(p_rdata0), .rdata1(p_rdata1), .rvalid0(p_rvalid0),
        .rvalid1(p_rvalid1), .count(p_count)
    );

    synth_regfile #(.WIDTH(8), .DEPTH(3), .NEGEDGE(1), .AW(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .inv(inv), .iaddr(iaddr), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(d_rdata0), .rdata1(d_rdata1), .rvalid0(d_rvalid0),
        .rvalid1(d_rvalid1), .count(d_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full clock: rising edge then falling edge, ending just after the fall.
    task automatic cyc();
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d; inv = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        inv = 1'b0; iaddr = '0; raddr0 = 2'd1; raddr1 = 2'd3;
        cyc();
        cyc();
        chk("rst_count_neg",   64'(n_count),   64'd0);
        chk("rst_rvalid0_neg", 64'(n_rvalid0), 64'd0);
        chk("rst_rdata0_neg",  64'(n_rdata0),  64'h0);
        chk("rst_rdata1_neg",  64'(n_rdata1),  64'h0);
        chk("rst_count_pos",   64'(p_count),   64'd0);
        chk("rst_count_d3",    64'(d_count),   64'd0);

        // First write: falling-edge instance must ignore the rising edge.
        rst_n = 1'b1; we = 1'b1; waddr = 2'd1; wdata = 8'hA5;
        @(posedge clk);
        #1;
        chk("neg_rise_rdata0",  64'(n_rdata0),  64'h0);
        chk("neg_rise_rvalid0", 64'(n_rvalid0), 64'd0);
        chk("neg_rise_count",   64'(n_count),   64'd0);
        chk("pos_rise_rdata0",  64'(p_rdata0),  64'hA5);
        chk("pos_rise_rvalid0", 64'(p_rvalid0), 64'd1);
        chk("pos_rise_count",   64'(p_count),   64'd1);
        @(negedge clk);
        #1;
        chk("neg_fall_rdata0",  64'(n_rdata0),  64'hA5);
        chk("neg_fall_rvalid0", 64'(n_rvalid0), 64'd1);
        chk("neg_fall_count",   64'(n_count),   64'd1);
        chk("pos_fall_count",   64'(p_count),   64'd1);
        we = 1'b0;

        // Fill 0..3; the DEPTH=3 instance drops address 3.
        wr(2'd0, 8'h11);
        wr(2'd1, 8'h22);
        wr(2'd2, 8'h33);
        wr(2'd3, 8'h44);
        we = 1'b0;
        raddr0 = 2'd3; raddr1 = 2'd2;
        #1;
        chk("fill_count_neg",  64'(n_count),   64'd4);
        chk("fill_count_pos",  64'(p_count),   64'd4);
        chk("d3_count",        64'(d_count),   64'd3);
        chk("d3_oob_rdata0",   64'(d_rdata0),  64'h0);
        chk("d3_oob_rvalid0",  64'(d_rvalid0), 64'd0);
        chk("d3_rdata1",       64'(d_rdata1),  64'h33);
        chk("fill_rdata0_neg", 64'(n_rdata0),  64'h44);

        // Rewrite a valid entry: count stays at 4.
        we = 1'b1; waddr = 2'd2; wdata = 8'h55;
        @(posedge clk);
        #1;
        chk("rewrite_mid_count", 64'(n_count), 64'd4);
        @(negedge clk);
        #1;
        chk("rewrite_count",  64'(n_count),  64'd4);
        chk("rewrite_rdata1", 64'(n_rdata1), 64'h55);

        // Write and invalidate the same valid entry: write wins.
        we = 1'b1; waddr = 2'd3; wdata = 8'h77; inv = 1'b1; iaddr = 2'd3;
        cyc();
        chk("wi_same_rvalid0", 64'(n_rvalid0), 64'd1);
        chk("wi_same_rdata0",  64'(n_rdata0),  64'h77);
        chk("wi_same_count",   64'(n_count),   64'd4);

        we = 1'b0;
        cyc();
        chk("inv_rvalid0", 64'(n_rvalid0), 64'd0);
        chk("inv_rdata0",  64'(n_rdata0),  64'h77);
        chk("inv_count",   64'(n_count),   64'd3);
        chk("d3_inv_oob_count", 64'(d_count), 64'd3);

        // Invalidating an already invalid entry leaves count alone.
        cyc();
        chk("inv_again_count", 64'(n_count), 64'd3);

        // Write invalid entry 3 and invalidate valid entry 0 together: net zero.
        we = 1'b1; waddr = 2'd3; wdata = 8'h99; inv = 1'b1; iaddr = 2'd0;
        raddr1 = 2'd0;
        cyc();
        chk("wi_diff_count",   64'(n_count),   64'd3);
        chk("wi_diff_rvalid0", 64'(n_rvalid0), 64'd1);
        chk("wi_diff_rdata0",  64'(n_rdata0),  64'h99);
        chk("wi_diff_rvalid1", 64'(n_rvalid1), 64'd0);
        chk("wi_diff_rdata1",  64'(n_rdata1),  64'h11);
        chk("d3_wi_count",     64'(d_count),   64'd2);

        // Both ports on the same entry.
        we = 1'b0; inv = 1'b0; raddr0 = 2'd2; raddr1 = 2'd2;
        #1;
        chk("same_rdata0", 64'(n_rdata0), 64'h55);
        chk("same_rdata1", 64'(n_rdata1), 64'h55);

        wr(2'd0, 8'hAA);
        chk("refill_count", 64'(n_count), 64'd4);

        // Reset with a write pending: write dropped, everything cleared.
        rst_n = 1'b0; we = 1'b1; waddr = 2'd1; wdata = 8'hEE;
        raddr0 = 2'd1; raddr1 = 2'd3;
        cyc();
        chk("mrst_count",   64'(n_count),   64'd0);
        chk("mrst_rvalid0", 64'(n_rvalid0), 64'd0);
        chk("mrst_rvalid1", 64'(n_rvalid1), 64'd0);
        chk("mrst_rdata0",  64'(n_rdata0),  64'h0);
        chk("mrst_rdata1",  64'(n_rdata1),  64'h0);
        chk("mrst_count_pos", 64'(p_count), 64'd0);

        rst_n = 1'b1;
        wr(2'd3, 8'h3C);
        we = 1'b0;
        #1;
        chk("resume_count",   64'(n_count),   64'd1);
        chk("resume_rdata1",  64'(n_rdata1),  64'h3C);
        chk("resume_rvalid0", 64'(n_rvalid0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
